data_ram: RTL and testbench
===========================

# data_ram

True dual-port, byte-writable, synchronous-read data memory of 32-bit words. Port A serves the CPU load/store path inside the write-back segment register. Port B serves the debug path. The block stores words only: the caller has already shifted write data and byte enables to the correct lanes. Byte selection for loads also happens outside this block.

## Interface
Parameters:
- ADDR_WIDTH, 12: word-address bits actually decoded; depth = 2^ADDR_WIDTH words (4096 words, 16 KiB).
- INIT_ZERO, 1: when 1, all words are zero at elaboration/time 0.

Ports:
- clk  in  1: single clock; all writes and reads happen on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- wea  in  4: port A byte write enables; bit i writes dina[8i+7:8i].
- addra  in  30: port A word address (byte address [31:2]).
- dina  in  32: port A write data.
- douta  out  32: port A registered read data.
- web  in  4: port B byte write enables.
- addrb  in  30: port B word address.
- dinb  in  32: port B write data.
- doutb  out  32: port B registered read data.

## Operation
- Effective index = addr[ADDR_WIDTH-1:0]; upper address bits are ignored, so addresses wrap modulo the depth.
- Write: on a rising edge with rst_n high, each set bit of the enable writes its byte lane; cleared lanes keep their old contents. Enables 4'b0000 mean a pure read.
- Read: every rising edge with rst_n high loads mem[index] into the output register of each port. This happens regardless of the enables.
- Same-port read during write: the output is read-first, i.e. the old word, unless the configuration macro selects write-first.
- Cross-port collision, both ports writing the same byte of the same word in one cycle: port A's byte wins.
- Cross-port read of a word being written by the other port in the same cycle returns the old contents.
- Reset (rst_n low): douta and doutb are forced to 32'h0 immediately and held there. Writes are ignored while rst_n is low. Memory contents are not cleared by reset.
- No enable/stall input. Hold and clear of the read data are the caller's responsibility.

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on dout after edge N and is stable for the whole following cycle.
- A write takes effect at edge N and is visible on a read issued at edge N+1 or later.
- Reset values: douta = 0, doutb = 0.
- Release: the first rising edge after rst_n deasserts performs a normal read/write.
- Reset asserted mid-cycle clears the outputs asynchronously. Any write on an edge while rst_n is low is dropped.

## Configuration
- DATA_RAM_WRITE_FIRST_EN, when defined: a same-port read during a write returns the newly merged word. The written lanes carry new data and the unwritten lanes carry old data.
- When undefined (default): read-first, returning the old word.
- Cross-port behaviour is unaffected by the macro.

## Structure
- Package data_ram_pkg holds:
  - DATA_W = 32, NUM_BYTES = 4, ADDR_IN_W = 30, DEFAULT_ADDR_WIDTH = 12.
  - A function that merges byte lanes (old word, new word, 4-bit enable) into the result word.
- Single memory array, inferred as block RAM, with two write/read processes; port A's write has priority over port B's.
- Sub-module data_ram_out_reg: one instance per port, holding the 32-bit output register with asynchronous clear. Its input selection covers the read-first/write-first choice.

## Test plan
- Reset:
  - Stimulus: rst_n=0, then raise it.
  - Required: douta = doutb = 0 during reset. After reading address 5, douta = 0 when INIT_ZERO = 1.
- Full-word write then read:
  - Stimulus: port A writes 32'hDEADBEEF to addra = 3 with wea = 4'hF, then reads addra = 3 on the next edge.
  - Required: douta = 32'hDEADBEEF one cycle after the read edge.
- Byte-lane merge:
  - Stimulus: after the previous write, wea = 4'b0010 with dina = 32'h0000AA00 at address 3.
  - Required: the read returns 32'hDEADAAEF.
  - Stimulus: a further write with wea = 4'b1100 and dina = 32'h12340000.
  - Required: the read returns 32'h1234AAEF.
- Read-during-write, default build:
  - Stimulus: address 7 holds 32'h11111111; port A writes 32'h22222222 to it.
  - Required: douta = 32'h11111111 on that edge and 32'h22222222 on the next read. With DATA_RAM_WRITE_FIRST_EN defined, the first output is 32'h22222222.
- Dual-port collision and visibility:
  - Stimulus: ports A and B both write address 9 in the same cycle, A with 32'hAAAAAAAA and B with 32'hBBBBBBBB, all enables set.
  - Required: port B then reads 32'hAAAAAAAA. Port B writing address 10 is readable on port A the following cycle.
- Wrap and reset mid-operation:
  - Stimulus: write 32'h5A5A5A5A via addra = 4096 + 2.
  - Required: a read of addra = 2 returns 32'h5A5A5A5A.
  - Stimulus: pulse rst_n low between edges, then read.
  - Required: outputs go to 0 at once, and memory still returns 32'h5A5A5A5A afterwards.

Source files
------------

// File: rtl/data_ram_pkg.sv
// Shared widths and the byte-lane merge helper for the dual-port data memory.
package data_ram_pkg;

  localparam int DATA_W             = 32;
  localparam int NUM_BYTES          = 4;
  localparam int ADDR_IN_W          = 30;
  localparam int DEFAULT_ADDR_WIDTH = 12;

  // Replace the lanes selected by be with new_word, keep the rest from old_word.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0]    old_word,
    input logic [DATA_W-1:0]    new_word,
    input logic [NUM_BYTES-1:0] be
  );
    logic [DATA_W-1:0] result;
    result = old_word;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (be[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/data_ram_out_reg.sv
// Registered read data for one port, cleared asynchronously by rst_n.
// DATA_RAM_WRITE_FIRST_EN selects write-first instead of read-first same-port data.
module data_ram_out_reg
  import data_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    old_word,
  input  logic [DATA_W-1:0]    new_word,
  input  logic [NUM_BYTES-1:0] we,
  output logic [DATA_W-1:0]    dout
);

`ifdef DATA_RAM_WRITE_FIRST_EN
  localparam bit WRITE_FIRST = 1'b1;
`else
  localparam bit WRITE_FIRST = 1'b0;
`endif

  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] next_word;

  assign merged_word = merge_bytes(old_word, new_word, we);
  assign next_word   = WRITE_FIRST ? merged_word : old_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= next_word;
  end

endmodule

// File: rtl/data_ram.sv
// True dual-port, byte-writable, synchronous-read word memory; A wins byte collisions.
// Optional macro DATA_RAM_WRITE_FIRST_EN makes same-port read-during-write return new data.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_BYTES-1:0] wea,
  input  logic [ADDR_IN_W-1:0] addra,
  input  logic [DATA_W-1:0]    dina,
  output logic [DATA_W-1:0]    douta,
  input  logic [NUM_BYTES-1:0] web,
  input  logic [ADDR_IN_W-1:0] addrb,
  input  logic [DATA_W-1:0]    dinb,
  output logic [DATA_W-1:0]    doutb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [DATA_W-1:0] INIT_WORD = INIT_ZERO ? '0 : 'x;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

  logic [ADDR_WIDTH-1:0] idx_a;
  logic [ADDR_WIDTH-1:0] idx_b;
  logic [DATA_W-1:0]     old_a;
  logic [DATA_W-1:0]     old_b;
  logic                  unused_addr_hi;

  // Upper address bits are ignored so the address space wraps modulo DEPTH.
  assign idx_a          = addra[ADDR_WIDTH-1:0];
  assign idx_b          = addrb[ADDR_WIDTH-1:0];
  assign unused_addr_hi = ^{addra[ADDR_IN_W-1:ADDR_WIDTH], addrb[ADDR_IN_W-1:ADDR_WIDTH]};

  assign old_a = mem[idx_a];
  assign old_b = mem[idx_b];

  // Port B lanes are scheduled first so a colliding port A lane overrides them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (web[i]) mem[idx_b][8*i +: 8] <= dinb[8*i +: 8];
        if (wea[i]) mem[idx_a][8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  data_ram_out_reg u_out_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .old_word (old_a),
    .new_word (dina),
    .we       (wea),
    .dout     (douta)
  );

  data_ram_out_reg u_out_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .old_word (old_b),
    .new_word (dinb),
    .we       (web),
    .dout     (doutb)
  );

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: stimulus queues expected read data, a monitor checks it.
module tb_data_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  wea, web;
  logic [29:0] addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  data_ram #(.ADDR_WIDTH(12), .INIT_ZERO(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta),
    .web   (web),
    .addrb (addrb),
    .dinb  (dinb),
    .doutb (doutb)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One clock of stimulus on both ports; the expected registered data goes to the scoreboard.
  task automatic applyStimulus(
    input string name,
    input logic [3:0] wa, input logic [29:0] aa, input logic [31:0] da,
    input bit chka, input logic [31:0] expa,
    input logic [3:0] wb, input logic [29:0] ab, input logic [31:0] db,
    input bit chkb, input logic [31:0] expb
  );
    exp_t ea, eb;
    @(negedge clk);
    wea = wa; addra = aa; dina = da;
    web = wb; addrb = ab; dinb = db;
    ea.chk = chka; ea.exp = expa; ea.name = {name, "/A"};
    eb.chk = chkb; eb.exp = expb; eb.name = {name, "/B"};
    qa.push_back(ea);
    qb.push_back(eb);
    @(posedge clk);
  endtask

  // Monitor: each active edge produces one output word per port.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (qa.size() > 0) begin
          e = qa.pop_front();
          if (e.chk) checkOutput(e.name, douta, e.exp);
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          if (e.chk) checkOutput(e.name, doutb, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int budget;
    rst_n = 1'b1;
    wea = '0; addra = '0; dina = '0;
    web = '0; addrb = '0; dinb = '0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_a", douta, 32'h0);
    checkOutput("reset_b", doutb, 32'h0);

    // A write attempted during reset must be dropped.
    @(negedge clk);
    wea = 4'hF; addra = 30'd5; dina = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    checkOutput("reset_hold_a", douta, 32'h0);
    checkOutput("reset_hold_b", doutb, 32'h0);
    @(negedge clk);
    wea = '0;
    rst_n = 1'b1;

    applyStimulus("read5",     4'h0, 30'd5, 32'h0,          1, 32'h0,
                               4'h0, 30'd5, 32'h0,          1, 32'h0);
`ifdef DATA_RAM_WRITE_FIRST_EN
    applyStimulus("wr3_full",  4'hF, 30'd3, 32'hDEADBEEF,   1, 32'hDEADBEEF,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`else
    applyStimulus("wr3_full",  4'hF, 30'd3, 32'hDEADBEEF,   1, 32'h0,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`endif
    applyStimulus("rd3_full",  4'h0, 30'd3, 32'h0,          1, 32'hDEADBEEF,
                               4'h0, 30'd3, 32'h0,          1, 32'hDEADBEEF);
`ifdef DATA_RAM_WRITE_FIRST_EN
    applyStimulus("wr3_b1",    4'b0010, 30'd3, 32'h0000AA00, 1, 32'hDEADAAEF,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`else
    applyStimulus("wr3_b1",    4'b0010, 30'd3, 32'h0000AA00, 1, 32'hDEADBEEF,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`endif
    applyStimulus("rd3_b1",    4'h0, 30'd3, 32'h0,          1, 32'hDEADAAEF,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`ifdef DATA_RAM_WRITE_FIRST_EN
    applyStimulus("wr3_b23",   4'b1100, 30'd3, 32'h12340000, 1, 32'h1234AAEF,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`else
    applyStimulus("wr3_b23",   4'b1100, 30'd3, 32'h12340000, 1, 32'hDEADAAEF,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`endif
    applyStimulus("rd3_b23",   4'h0, 30'd3, 32'h0,          1, 32'h1234AAEF,
                               4'h0, 30'd3, 32'h0,          1, 32'h1234AAEF);

    applyStimulus("wr7_first", 4'hF, 30'd7, 32'h11111111,   0, 32'h0,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
`ifdef DATA_RAM_WRITE_FIRST_EN
    applyStimulus("rdw7",      4'hF, 30'd7, 32'h22222222,   1, 32'h22222222,
                               4'h0, 30'd7, 32'h0,          1, 32'h11111111);
`else
    applyStimulus("rdw7",      4'hF, 30'd7, 32'h22222222,   1, 32'h11111111,
                               4'h0, 30'd7, 32'h0,          1, 32'h11111111);
`endif
    applyStimulus("rd7",       4'h0, 30'd7, 32'h0,          1, 32'h22222222,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);

    // Same-word collision on address 9: port A must win every byte.
    applyStimulus("coll9",     4'hF, 30'd9, 32'hAAAAAAAA,   0, 32'h0,
                               4'hF, 30'd9, 32'hBBBBBBBB,   0, 32'h0);
    applyStimulus("rd9",       4'h0, 30'd3, 32'h0,          1, 32'h1234AAEF,
                               4'h0, 30'd9, 32'h0,          1, 32'hAAAAAAAA);
    applyStimulus("wrb10",     4'h0, 30'd10, 32'h0,         1, 32'h0,
                               4'hF, 30'd10, 32'hCAFEF00D,  0, 32'h0);
    applyStimulus("rd10",      4'h0, 30'd10, 32'h0,         1, 32'hCAFEF00D,
                               4'h0, 30'd10, 32'h0,         1, 32'hCAFEF00D);
    applyStimulus("coll11",    4'b0011, 30'd11, 32'h00001122, 0, 32'h0,
                               4'b0110, 30'd11, 32'h00334400, 0, 32'h0);
    applyStimulus("rd11",      4'h0, 30'd11, 32'h0,         1, 32'h00331122,
                               4'h0, 30'd11, 32'h0,         1, 32'h00331122);

    applyStimulus("wrap_wr",   4'hF, 30'd4098, 32'h5A5A5A5A, 0, 32'h0,
                               4'h0, 30'd0, 32'h0,          0, 32'h0);
    applyStimulus("wrap_rd",   4'h0, 30'd2, 32'h0,          1, 32'h5A5A5A5A,
                               4'h0, 30'd8194, 32'h0,       1, 32'h5A5A5A5A);

    // Mid-cycle reset: outputs clear at once, a write during reset is dropped.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_a", douta, 32'h0);
    checkOutput("midrst_b", doutb, 32'h0);
    @(negedge clk);
    wea = 4'hF; addra = 30'd2; dina = 32'h0;
    @(posedge clk);
    #1;
    checkOutput("midrst_hold_a", douta, 32'h0);
    @(negedge clk);
    wea = '0;
    rst_n = 1'b1;
    applyStimulus("post_rst",  4'h0, 30'd2, 32'h0,          1, 32'h5A5A5A5A,
                               4'h0, 30'd2, 32'h0,          1, 32'h5A5A5A5A);

    budget = 10;
    while ((qa.size() > 0 || qb.size() > 0) && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (qa.size() > 0 || qb.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", qa.size() + qb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
